// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Control FSM for a multicycle MIPS-subset datapath. It
//                sequences lw, sw, R-type (add/sub/and/or/slt/nor), beq,
//                addi and j. A memory handshake stretches FETCH, MEMREAD and
//                MEMWRITE. Unsupported encodings are flagged in DECODE.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemoryRead,
  output logic       MemoryWrite,
  output logic       IRWrite,
  output logic       MemoryToRegister,
  output logic       RegisterDestination,
  output logic       RegisterWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUControl,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  // State encodings are visible on the debug port, so they are fixed here.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // Opcodes
  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] C_FN_ADD = 6'b100000;
  localparam logic [5:0] C_FN_SUB = 6'b100010;
  localparam logic [5:0] C_FN_AND = 6'b100100;
  localparam logic [5:0] C_FN_OR  = 6'b100101;
  localparam logic [5:0] C_FN_SLT = 6'b101010;
  localparam logic [5:0] C_FN_NOR = 6'b100111;

  // ALU operations
  localparam logic [3:0] C_ALU_AND = 4'b0000;
  localparam logic [3:0] C_ALU_OR  = 4'b0001;
  localparam logic [3:0] C_ALU_ADD = 4'b0010;
  localparam logic [3:0] C_ALU_SUB = 4'b0110;
  localparam logic [3:0] C_ALU_SLT = 4'b0111;
  localparam logic [3:0] C_ALU_NOR = 4'b1100;

  // ALU operand B sources
  localparam logic [1:0] C_SRCB_REG   = 2'b00;
  localparam logic [1:0] C_SRCB_FOUR  = 2'b01;
  localparam logic [1:0] C_SRCB_IMM   = 2'b10;
  localparam logic [1:0] C_SRCB_IMMSH = 2'b11;

  // PC sources
  localparam logic [1:0] C_PCSRC_ALU    = 2'b00;
  localparam logic [1:0] C_PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] C_PCSRC_JUMP   = 2'b10;

  state_t state_q, state_d;

  // Raw FSM outputs, before the reset gating on the side-effecting strobes
  logic       w_pc_write;
  logic       w_ior_d;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_mem_to_reg;
  logic       w_reg_dst;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_pc_source;
  logic [3:0] w_alu_control;
  logic       w_instr_done;
  logic       w_illegal;

  // Decoded R-type function: legality flag and matching ALU operation
  logic       w_funct_legal;
  logic [3:0] w_funct_alu;

  // Map the R-type funct field to an ALU operation and flag unsupported codes
  always_comb begin
    w_funct_legal = 1'b1;
    w_funct_alu   = C_ALU_ADD;
    case (funct)
      C_FN_ADD: w_funct_alu = C_ALU_ADD;
      C_FN_SUB: w_funct_alu = C_ALU_SUB;
      C_FN_AND: w_funct_alu = C_ALU_AND;
      C_FN_OR:  w_funct_alu = C_ALU_OR;
      C_FN_SLT: w_funct_alu = C_ALU_SLT;
      C_FN_NOR: w_funct_alu = C_ALU_NOR;
      default:  w_funct_legal = 1'b0;
    endcase
  end

  // State register; reset abandons any in-flight instruction or memory wait
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control outputs; anything unlisted stays 0
  always_comb begin
    state_d       = S_FETCH;
    w_pc_write    = 1'b0;
    w_ior_d       = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_reg_dst     = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = C_SRCB_REG;
    w_pc_source   = C_PCSRC_ALU;
    w_alu_control = C_ALU_AND;
    w_instr_done  = 1'b0;
    w_illegal     = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle but only committed with the IR
        w_mem_read    = 1'b1;
        w_alu_src_b   = C_SRCB_FOUR;
        w_alu_control = C_ALU_ADD;
        w_pc_source   = C_PCSRC_ALU;
        w_ir_write    = mem_ready;
        w_pc_write    = mem_ready;
        state_d       = mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // Speculative branch target PC + (imm << 2) lands in ALUOut
        w_alu_src_b   = C_SRCB_IMMSH;
        w_alu_control = C_ALU_ADD;
        case (opcode)
          C_OP_RTYPE: begin
            if (w_funct_legal) begin
              state_d = S_EXECUTE;
            end else begin
              state_d   = S_FETCH;
              w_illegal = 1'b1;
            end
          end
          C_OP_LW, C_OP_SW: state_d = S_MEMADR;
          C_OP_BEQ:         state_d = S_BRANCH;
          C_OP_ADDI:        state_d = S_ADDIEXEC;
          C_OP_J:           state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = C_SRCB_IMM;
        w_alu_control = C_ALU_ADD;
        // The IR is stable here, so only lw/sw can reach this state
        state_d       = (opcode == C_OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        w_mem_read = 1'b1;
        w_ior_d    = 1'b1;
        state_d    = mem_ready ? S_MEMWB : S_MEMREAD;
      end

      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_instr_done = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEMWRITE: begin
        w_mem_write  = 1'b1;
        w_ior_d      = 1'b1;
        w_instr_done = mem_ready;
        state_d      = mem_ready ? S_FETCH : S_MEMWRITE;
      end

      S_EXECUTE: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = C_SRCB_REG;
        w_alu_control = w_funct_alu;
        state_d       = S_ALUWB;
      end

      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_instr_done = 1'b1;
        state_d      = S_FETCH;
      end

      S_BRANCH: begin
        // Comparison by subtraction; target was precomputed in DECODE
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = C_SRCB_REG;
        w_alu_control = C_ALU_SUB;
        w_pc_source   = C_PCSRC_ALUOUT;
        w_pc_write    = Zero;
        w_instr_done  = 1'b1;
        state_d       = S_FETCH;
      end

      S_ADDIEXEC: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = C_SRCB_IMM;
        w_alu_control = C_ALU_ADD;
        state_d       = S_ADDIWB;
      end

      S_ADDIWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        state_d      = S_FETCH;
      end

      S_JUMP: begin
        w_pc_source  = C_PCSRC_JUMP;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
        state_d      = S_FETCH;
      end

      // Unused codes 12-15 recover to FETCH with all outputs quiet
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Drive ports; side-effecting strobes are suppressed while reset is held
  always_comb begin
    PCWrite             = w_pc_write   & reset;
    IRWrite             = w_ir_write   & reset;
    RegisterWrite       = w_reg_write  & reset;
    MemoryWrite         = w_mem_write  & reset;
    MemoryRead          = w_mem_read   & reset;
    instr_done          = w_instr_done & reset;
    illegal             = w_illegal    & reset;
    IorD                = w_ior_d;
    MemoryToRegister    = w_mem_to_reg;
    RegisterDestination = w_reg_dst;
    ALUSrcA             = w_alu_src_a;
    ALUSrcB             = w_alu_src_b;
    PCSource            = w_pc_source;
    ALUControl          = w_alu_control;
    state               = state_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Directed self-checking bench for multicycle_control.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, IorD, MemoryRead, MemoryWrite, IRWrite;
  logic       MemoryToRegister, RegisterDestination, RegisterWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUControl, state;
  logic       instr_done, illegal;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_control dut (
    .clk                 (clk),
    .reset               (reset),
    .opcode              (opcode),
    .funct               (funct),
    .Zero                (Zero),
    .mem_ready           (mem_ready),
    .PCWrite             (PCWrite),
    .IorD                (IorD),
    .MemoryRead          (MemoryRead),
    .MemoryWrite         (MemoryWrite),
    .IRWrite             (IRWrite),
    .MemoryToRegister    (MemoryToRegister),
    .RegisterDestination (RegisterDestination),
    .RegisterWrite       (RegisterWrite),
    .ALUSrcA             (ALUSrcA),
    .ALUSrcB             (ALUSrcB),
    .PCSource            (PCSource),
    .ALUControl          (ALUControl),
    .state               (state),
    .instr_done          (instr_done),
    .illegal             (illegal)
  );

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sd(input string tag, input logic [3:0] st, input logic done);
    check({tag, "_state"}, {28'd0, state}, {28'd0, st});
    check({tag, "_done"}, {31'd0, instr_done}, {31'd0, done});
  endtask

  // Checks of a FETCH cycle with mem_ready=1
  task automatic chk_fetch(input string tag);
    chk_sd(tag, 4'd0, 1'b0);
    check({tag, "_mread"}, {31'd0, MemoryRead}, 32'd1);
    check({tag, "_irw"},   {31'd0, IRWrite},    32'd1);
    check({tag, "_pcw"},   {31'd0, PCWrite},    32'd1);
    check({tag, "_srcb"},  {30'd0, ALUSrcB},    32'd1);
    check({tag, "_alu"},   {28'd0, ALUControl}, 32'd2);
    check({tag, "_iord"},  {31'd0, IorD},       32'd0);
  endtask

  logic [5:0] fn_tab  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
  logic [3:0] alu_tab [6] = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b1100};

  initial begin
    reset = 1'b0; opcode = 6'd0; funct = 6'd0; Zero = 1'b0; mem_ready = 1'b1;
    #1;
    // Strobes forced low during reset even though FETCH would drive them
    check("rst_mread", {31'd0, MemoryRead}, 32'd0);
    check("rst_irw",   {31'd0, IRWrite},    32'd0);
    check("rst_pcw",   {31'd0, PCWrite},    32'd0);
    cyc();
    chk_sd("rst", 4'd0, 1'b0);
    cyc();
    reset = 1'b1;
    opcode = 6'b100011;
    #1;
    // ---- lw: 0,1,2,3,4
    chk_fetch("lw_f");
    cyc();
    chk_sd("lw_dec", 4'd1, 1'b0);
    check("lw_dec_srcb", {30'd0, ALUSrcB}, 32'd3);
    cyc();
    chk_sd("lw_adr", 4'd2, 1'b0);
    check("lw_adr_srca", {31'd0, ALUSrcA}, 32'd1);
    check("lw_adr_srcb", {30'd0, ALUSrcB}, 32'd2);
    cyc();
    chk_sd("lw_rd", 4'd3, 1'b0);
    check("lw_rd_mread", {31'd0, MemoryRead}, 32'd1);
    check("lw_rd_iord",  {31'd0, IorD},       32'd1);
    cyc();
    chk_sd("lw_wb", 4'd4, 1'b1);
    check("lw_wb_rw",  {31'd0, RegisterWrite},    32'd1);
    check("lw_wb_m2r", {31'd0, MemoryToRegister}, 32'd1);
    check("lw_wb_dst", {31'd0, RegisterDestination}, 32'd0);
    cyc();

    // ---- R-type: every supported funct
    for (int i = 0; i < 6; i++) begin
      opcode = 6'b000000; funct = fn_tab[i];
      #1;
      chk_fetch("r_f");
      cyc();
      chk_sd("r_dec", 4'd1, 1'b0);
      check("r_dec_ill", {31'd0, illegal}, 32'd0);
      cyc();
      chk_sd("r_ex", 4'd6, 1'b0);
      check("r_ex_alu",  {28'd0, ALUControl}, {28'd0, alu_tab[i]});
      check("r_ex_srca", {31'd0, ALUSrcA},    32'd1);
      check("r_ex_srcb", {30'd0, ALUSrcB},    32'd0);
      cyc();
      chk_sd("r_wb", 4'd7, 1'b1);
      check("r_wb_dst", {31'd0, RegisterDestination}, 32'd1);
      check("r_wb_rw",  {31'd0, RegisterWrite},       32'd1);
      check("r_wb_m2r", {31'd0, MemoryToRegister},    32'd0);
      cyc();
    end

    // ---- beq with Zero=1 then Zero=0
    for (int z = 1; z >= 0; z--) begin
      opcode = 6'b000100; Zero = z[0];
      #1;
      chk_fetch("beq_f");
      cyc();
      chk_sd("beq_dec", 4'd1, 1'b0);
      cyc();
      chk_sd("beq_br", 4'd8, 1'b1);
      check("beq_pcw",   {31'd0, PCWrite},    {31'd0, z[0]});
      check("beq_pcsrc", {30'd0, PCSource},   32'd1);
      check("beq_alu",   {28'd0, ALUControl}, 32'd6);
      cyc();
      chk_sd("beq_next", 4'd0, 1'b0);
    end

    // ---- sw with three wait cycles in MEMWRITE
    opcode = 6'b101011;
    #1;
    chk_fetch("sw_f");
    cyc();
    chk_sd("sw_dec", 4'd1, 1'b0);
    cyc();
    chk_sd("sw_adr", 4'd2, 1'b0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      #1;
      chk_sd("sw_wr", 4'd5, (k == 3));
      check("sw_wr_mw",   {31'd0, MemoryWrite}, 32'd1);
      check("sw_wr_iord", {31'd0, IorD},        32'd1);
      check("sw_wr_mr",   {31'd0, MemoryRead},  32'd0);
      cyc();
    end
    chk_sd("sw_next", 4'd0, 1'b0);

    // ---- addi: 0,1,9,10
    opcode = 6'b001000;
    #1;
    chk_fetch("addi_f");
    cyc();
    cyc();
    chk_sd("addi_ex", 4'd9, 1'b0);
    check("addi_ex_srcb", {30'd0, ALUSrcB}, 32'd2);
    cyc();
    chk_sd("addi_wb", 4'd10, 1'b1);
    check("addi_wb_rw",  {31'd0, RegisterWrite},       32'd1);
    check("addi_wb_dst", {31'd0, RegisterDestination}, 32'd0);
    cyc();

    // ---- jump: 0,1,11
    opcode = 6'b000010;
    #1;
    chk_fetch("j_f");
    cyc();
    cyc();
    chk_sd("j_jmp", 4'd11, 1'b1);
    check("j_pcw",   {31'd0, PCWrite},  32'd1);
    check("j_pcsrc", {30'd0, PCSource}, 32'd2);
    cyc();

    // ---- illegal opcode
    opcode = 6'b111111;
    #1;
    chk_fetch("ilop_f");
    cyc();
    chk_sd("ilop_dec", 4'd1, 1'b0);
    check("ilop_ill", {31'd0, illegal},       32'd1);
    check("ilop_rw",  {31'd0, RegisterWrite}, 32'd0);
    check("ilop_pcw", {31'd0, PCWrite},       32'd0);
    check("ilop_irw", {31'd0, IRWrite},       32'd0);
    check("ilop_mw",  {31'd0, MemoryWrite},   32'd0);
    cyc();
    chk_sd("ilop_next", 4'd0, 1'b0);
    check("ilop_ill_gone", {31'd0, illegal}, 32'd0);

    // ---- illegal R-type funct
    opcode = 6'b000000; funct = 6'b000000;
    #1;
    cyc();
    chk_sd("ilfn_dec", 4'd1, 1'b0);
    check("ilfn_ill", {31'd0, illegal}, 32'd1);
    cyc();
    chk_sd("ilfn_next", 4'd0, 1'b0);

    // ---- FETCH wait: no IR/PC load, stays in FETCH
    mem_ready = 1'b0;
    #1;
    check("fw_irw",   {31'd0, IRWrite},    32'd0);
    check("fw_pcw",   {31'd0, PCWrite},    32'd0);
    check("fw_mread", {31'd0, MemoryRead}, 32'd1);
    cyc();
    chk_sd("fw_hold", 4'd0, 1'b0);

    // ---- reset during a MEMREAD wait
    mem_ready = 1'b1; opcode = 6'b100011;
    #1;
    cyc();
    cyc();
    cyc();
    mem_ready = 1'b0;
    #1;
    chk_sd("rmr_rd", 4'd3, 1'b0);
    check("rmr_mread", {31'd0, MemoryRead}, 32'd1);
    cyc();
    chk_sd("rmr_hold", 4'd3, 1'b0);
    reset = 1'b0;
    #1;
    check("rmr_rst_mread", {31'd0, MemoryRead}, 32'd0);
    cyc();
    chk_sd("rmr_after", 4'd0, 1'b0);
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    chk_fetch("rmr_f");
    cyc();
    chk_sd("rmr_dec", 4'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 opcode  input  6  Instruction[31:26] from the instruction register.
REQ-005 funct  input  6  Instruction[5:0] from the instruction register.
REQ-006 Zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory handshake; 1 = access completes this cycle.
REQ-008 PCWrite  output  1  PC load enable.
REQ-009 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 MemoryRead, MemoryWrite  output  1 each  memory strobes.
REQ-011 IRWrite  output  1  instruction register load enable.
REQ-012 MemoryToRegister, RegisterDestination, RegisterWrite  output  1 each  register-file write controls.
REQ-013 ALUSrcA  output  1  0 = PC, 1 = register A.
REQ-014 ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-015 PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-016 ALUControl  output  4  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-017 state  output  4  current state encoding, for debug.
REQ-018 instr_done  output  1  one-cycle pulse in the last cycle of each instruction.
REQ-019 illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode/funct.

Function
REQ-020 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11; codes 12-15 go to FETCH on the next edge.
REQ-021 FETCH: MemoryRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSource=00; IRWrite=PCWrite=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-022 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=ADD. Next state by opcode:
  - 000000 -> EXECUTE
  - 100011/101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEXEC
  - 000010 -> JUMP
  - else -> FETCH with illegal=1
REQ-023 R-type funct other than 100000/100010/100100/100101/101010/100111 -> FETCH with illegal=1.
REQ-024 MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; lw -> MEMREAD, sw -> MEMWRITE.
REQ-025 MEMREAD: MemoryRead=1, IorD=1; hold until mem_ready=1, then go to MEMWB.
REQ-026 MEMWB: RegisterWrite=1, MemoryToRegister=1, RegisterDestination=0; go to FETCH.
REQ-027 MEMWRITE: MemoryWrite=1, IorD=1; hold until mem_ready=1, then go to FETCH.
REQ-028 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from funct (add ADD, sub SUB, and AND, or OR, slt SLT, nor NOR); go to ALUWB.
REQ-029 ALUWB: RegisterWrite=1, RegisterDestination=1, MemoryToRegister=0; go to FETCH.
REQ-030 BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, PCWrite=Zero; go to FETCH.
REQ-031 ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ADD; go to ADDIWB. ADDIWB: RegisterWrite=1, RegisterDestination=0, MemoryToRegister=0; go to FETCH.
REQ-032 JUMP: PCSource=10, PCWrite=1; go to FETCH.
REQ-033 Every output not listed for a state is 0.
REQ-034 instr_done=1 in the cycle whose next state is FETCH from MEMWB, ALUWB, ADDIWB, BRANCH, JUMP or MEMWRITE (mem_ready=1); it is 0 for illegal exits.
REQ-035 Latency with mem_ready=1: lw 5 cycles; R-type, sw and addi 4; beq and j 3.
REQ-036 MemoryRead and MemoryWrite are never both 1; strobes and addresses are held stable through wait cycles.

Reset
REQ-037 reset=0 at a rising edge: state=FETCH, abandoning any in-flight instruction, including a memory wait.
REQ-038 While reset=0, PCWrite, IRWrite, RegisterWrite, MemoryWrite, MemoryRead, instr_done and illegal are forced to 0 combinationally.
REQ-039 First fetch begins in the first cycle after reset is released.

Verification
REQ-040 lw (opcode 100011), mem_ready=1 -> states 0,1,2,3,4; RegisterWrite=1 and MemoryToRegister=1 in cycle 5; instr_done once.
REQ-041 R-type with funct 101010 -> ALUControl=0111 in EXECUTE; RegisterDestination=1 in ALUWB; 4 cycles.
REQ-042 beq, Zero=1 then Zero=0 -> PCWrite=1 with PCSource=01 in BRANCH, then PCWrite=0; 3 cycles each.
REQ-043 sw with mem_ready low for 3 cycles in MEMWRITE -> MemoryWrite=1 and IorD=1 held 4 cycles; state 5 held; instr_done on the 4th cycle.
REQ-044 opcode 111111 -> illegal=1 in DECODE, no write enables asserted, FETCH next; instr_done stays 0.
REQ-045 reset=0 during a MEMREAD wait -> MemoryRead=0 immediately; state=0 after the edge; a clean fetch after release.
